// File: rtl/truth_table_driver.sv
// truth_table_driver: sweeps every input vector of an N_IN-input gate in
// ascending order. After SETTLE cycles it samples the gate output and checks
// it against EXP_TABLE. It reports pass/fail, the mismatch count and the
// first failing vector.
module truth_table_driver #(
    parameter int                     N_IN      = 2,
    parameter int                     SETTLE    = 1,
    parameter logic [(1<<N_IN)-1:0]   EXP_TABLE = 4'b1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   vec_out,
    input  logic              dut_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              fail_valid,
    output logic [N_IN-1:0]   fail_vec
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0]      CNT_LAST = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;

    logic [1:0]      state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N_IN:0]   err_q, err_d;
    logic            fail_valid_q, fail_valid_d;
    logic [N_IN-1:0] fail_vec_q, fail_vec_d;
    logic            pass_q, pass_d;
    logic            mismatch;

    // dut_y is a combinational function of vec_out, so it is compared as-is.
    assign mismatch = (dut_y != EXP_TABLE[vec_q]);

    // Next-state logic for the sweep sequencer and the result registers.
    always_comb begin
        // NOTE: every next-state signal defaults to its current value, so no
        // path through the case statement can infer a latch.
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        pass_d       = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    vec_d        = '0;
                    cnt_d        = '0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = '0;
                    pass_d       = 1'b0;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + (N_IN+1)'(1);
                    // Only the first failing vector is kept.
                    if (!fail_valid_q) begin
                        fail_vec_d   = vec_q;
                        fail_valid_d = 1'b1;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + N_IN'(1);
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                pass_d  = (err_q == '0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the pre-edge values.
        if (rst) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            cnt_q        <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            pass_q       <= pass_d;
        end
    end

    assign vec_out    = vec_q;
    assign busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_truth_table_driver.sv
// Bench for truth_table_driver.
// DUT a uses the default AND2 configuration.
// DUT b uses N_IN=3, SETTLE=3 and the XOR3 table.
// A gate model drives dut_y. The expected per-cycle outputs are queued before
// each sweep and are popped as the sweep runs.
module tb_truth_table_driver;

    localparam logic [7:0] AND2_TABLE = 8'b0000_1000;
    localparam logic [7:0] XOR3_TABLE = 8'b1001_0110;

    typedef struct {
        logic [2:0] vec;
        logic       busy;
        logic       done;
    } exp_cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic sel_r = 1'b0;
    int   mode = 0;

    int cmp_cnt = 0;
    int mis_cnt = 0;

    exp_cyc_t sb[$];

    logic       start_a, start_b;
    logic [1:0] vec_a, fvec_a;
    logic [2:0] vec_b, fvec_b, err_a;
    logic [3:0] err_b;
    logic       y_a, y_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b, fv_a, fv_b;

    logic [2:0] cur_vec, cur_fvec;
    logic [3:0] cur_err;
    logic       cur_busy, cur_done, cur_pass, cur_fv;

    // Gate model: mode 0 is the ideal gate, 1 is OR2 and 2 is stuck-at-1.
    function automatic logic gate_model(input logic sel, input int md, input logic [2:0] v);
        if (sel) return ^v;
        case (md)
            1:       return v[0] | v[1];
            2:       return 1'b1;
            default: return v[0] & v[1];
        endcase
    endfunction

    function automatic logic exp_bit(input logic sel, input int k);
        return sel ? XOR3_TABLE[k] : AND2_TABLE[k];
    endfunction

    always #5 clk = ~clk;

    assign start_a = start & ~sel_r;
    assign start_b = start & sel_r;
    assign y_a = gate_model(1'b0, mode, {1'b0, vec_a});
    assign y_b = gate_model(1'b1, mode, vec_b);

    assign cur_vec  = sel_r ? vec_b  : {1'b0, vec_a};
    assign cur_fvec = sel_r ? fvec_b : {1'b0, fvec_a};
    assign cur_err  = sel_r ? err_b  : {1'b0, err_a};
    assign cur_busy = sel_r ? busy_b : busy_a;
    assign cur_done = sel_r ? done_b : done_a;
    assign cur_pass = sel_r ? pass_b : pass_a;
    assign cur_fv   = sel_r ? fv_b   : fv_a;

    truth_table_driver u_and (
        .clk(clk), .rst(rst), .start(start_a), .vec_out(vec_a), .dut_y(y_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .fail_valid(fv_a), .fail_vec(fvec_a)
    );

    truth_table_driver #(.N_IN(3), .SETTLE(3), .EXP_TABLE(XOR3_TABLE)) u_xor (
        .clk(clk), .rst(rst), .start(start_b), .vec_out(vec_b), .dut_y(y_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_valid(fv_b), .fail_vec(fvec_b)
    );

    // Runs one sweep on the selected DUT.
    // p1/p2 are the cycles in which start is pulsed during the sweep.
    // rst_at is the cycle in which reset is asserted (0 means never).
    task automatic run_sweep(input logic sel, input int md, input int p1, input int p2, input int rst_at);
        int n_vec = sel ? 8 : 4;
        int per   = sel ? 4 : 2;
        int last  = n_vec * per + 1;
        int exp_err = 0;
        logic exp_fv = 1'b0;
        logic [2:0] exp_fvec = '0;
        exp_cyc_t e;
        sel_r = sel;
        mode  = md;
        for (int c = 1; c <= last; c++) begin
            e.vec  = (c < last) ? 3'((c - 1) / per) : 3'(n_vec - 1);
            e.busy = (c < last);
            e.done = (c == last);
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            cmp_cnt++; if (cur_vec !== e.vec) begin mis_cnt++; $display("FAIL vec_out cyc %0d: got %0d exp %0d", c, cur_vec, e.vec); end
            cmp_cnt++; if (cur_busy !== e.busy) begin mis_cnt++; $display("FAIL busy cyc %0d: got %b exp %b", c, cur_busy, e.busy); end
            cmp_cnt++; if (cur_done !== e.done) begin mis_cnt++; $display("FAIL done cyc %0d: got %b exp %b", c, cur_done, e.done); end
            cmp_cnt++; if (cur_err !== 4'(exp_err)) begin mis_cnt++; $display("FAIL err_count cyc %0d: got %0d exp %0d", c, cur_err, exp_err); end
            cmp_cnt++; if (cur_fv !== exp_fv) begin mis_cnt++; $display("FAIL fail_valid cyc %0d: got %b exp %b", c, cur_fv, exp_fv); end
            cmp_cnt++; if (cur_fvec !== exp_fvec) begin mis_cnt++; $display("FAIL fail_vec cyc %0d: got %0d exp %0d", c, cur_fvec, exp_fvec); end
            cmp_cnt++; if (cur_pass !== 1'b0) begin mis_cnt++; $display("FAIL pass_busy cyc %0d: got %b exp 0", c, cur_pass); end
            // The vector sampled in this cycle affects the counters from the next cycle.
            if ((c % per) == 0 && c < last) begin
                if (gate_model(sel, md, 3'(c / per - 1)) != exp_bit(sel, c / per - 1)) begin
                    if (!exp_fv) begin
                        exp_fv   = 1'b1;
                        exp_fvec = 3'(c / per - 1);
                    end
                    exp_err++;
                end
            end
            start = (c == p1) || (c == p2);
            if (c == rst_at) begin
                rst = 1'b1;
                start = 1'b0;
                @(negedge clk);
                cmp_cnt++; if ({cur_vec, cur_busy, cur_done, cur_pass, cur_err, cur_fv, cur_fvec} !== '0) begin
                    mis_cnt++;
                    $display("FAIL mid_reset: got vec=%0d busy=%b done=%b pass=%b err=%0d fv=%b fvec=%0d exp all 0",
                             cur_vec, cur_busy, cur_done, cur_pass, cur_err, cur_fv, cur_fvec);
                end
                rst = 1'b0;
                for (int i = 0; i < last; i++) begin
                    @(negedge clk);
                    cmp_cnt++; if (cur_done !== 1'b0 || cur_busy !== 1'b0) begin mis_cnt++; $display("FAIL post_reset_idle: got done=%b busy=%b exp 0 0", cur_done, cur_busy); end
                end
                sb.delete();
                return;
            end
        end
        @(negedge clk);
        start = 1'b0;
        cmp_cnt++; if (cur_busy !== 1'b0 || cur_done !== 1'b0) begin mis_cnt++; $display("FAIL after_done: got busy=%b done=%b exp 0 0", cur_busy, cur_done); end
        cmp_cnt++; if (cur_pass !== (exp_err == 0)) begin mis_cnt++; $display("FAIL pass: got %b exp %b", cur_pass, exp_err == 0); end
        cmp_cnt++; if (cur_err !== 4'(exp_err)) begin mis_cnt++; $display("FAIL final_err: got %0d exp %0d", cur_err, exp_err); end
        cmp_cnt++; if (cur_fv !== exp_fv || cur_fvec !== exp_fvec) begin mis_cnt++; $display("FAIL final_fail: got fv=%b fvec=%0d exp fv=%b fvec=%0d", cur_fv, cur_fvec, exp_fv, exp_fvec); end
        @(negedge clk);
        cmp_cnt++; if (cur_busy !== 1'b0 || cur_done !== 1'b0) begin mis_cnt++; $display("FAIL idle_after: got busy=%b done=%b exp 0 0", cur_busy, cur_done); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_cnt++; if ({vec_a, busy_a, done_a, pass_a, err_a, fv_a, fvec_a} !== '0) begin mis_cnt++; $display("FAIL reset_and: got %b exp 0", {vec_a, busy_a, done_a, pass_a, err_a, fv_a, fvec_a}); end
        cmp_cnt++; if ({vec_b, busy_b, done_b, pass_b, err_b, fv_b, fvec_b} !== '0) begin mis_cnt++; $display("FAIL reset_xor: got %b exp 0", {vec_b, busy_b, done_b, pass_b, err_b, fv_b, fvec_b}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_and_ideal();      run_sweep(1'b0, 0, 0, 0, 0); endtask
    task automatic test_or_gate();        run_sweep(1'b0, 1, 0, 0, 0); endtask
    task automatic test_stuck_then_clear();
        run_sweep(1'b0, 2, 0, 0, 0);
        run_sweep(1'b0, 0, 0, 0, 0);
    endtask
    task automatic test_xor3();           run_sweep(1'b1, 0, 0, 0, 0); endtask
    task automatic test_reset_mid_sweep();
        run_sweep(1'b0, 2, 0, 0, 5);
        run_sweep(1'b0, 0, 0, 0, 0);
    endtask
    task automatic test_start_ignored();  run_sweep(1'b0, 0, 3, 9, 0); endtask

    initial begin
        test_reset();
        test_and_ideal();
        test_or_gate();
        test_stuck_then_clear();
        test_xor3();
        test_reset_mid_sweep();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule

// File: doc/truth_table_driver.md
Name: truth_table_driver

Overview:
Sequential stimulus/checker stage wrapped around a small combinational gate under test (AND, OR, XOR…). Drives every input combination of an N-input gate in ascending order and waits a programmable settle time. It then samples the gate's output, compares it against a parameterised expected truth table, and reports pass/fail, error count and first failing vector. It is the synthesizable replacement for hand-written vector sequences in the gate benches, and it feeds and consumes the gate directly.

Parameters:
N_IN, 2, number of gate inputs (1..6); vector width.
SETTLE, 1, cycles between driving a vector and sampling dut_y (1..15).
EXP_TABLE, 4'b1000, expected output per vector, width 2**N_IN; bit k = expected y when vec_out == k (default = 2-input AND).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous active-high reset.
start  in  1  begin a sweep; accepted only in IDLE.
vec_out  out  N_IN  input vector driven to the gate; bit 0 = input a, bit 1 = input b, ….
dut_y  in  1  gate output being checked.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse when the sweep completes.
pass  out  1  1 iff last sweep had zero mismatches; held until next accepted start.
err_count  out  N_IN+1  mismatches in current/last sweep.
fail_valid  out  1  at least one mismatch captured.
fail_vec  out  N_IN  first mismatching vector; valid when fail_valid.

Behaviour:
- Reset (synchronous, active-high; overrides all other inputs) values: state IDLE, vec_out 0, busy 0, done 0, pass 0, err_count 0, fail_valid 0, fail_vec 0, settle counter 0.
- Reset mid-sweep: abandon the sweep next edge; no done pulse; all outputs take reset values.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 -> vec_out<=0, err_count<=0, fail_valid<=0, fail_vec<=0, pass<=0, cnt<=0, busy<=1, go SETTLE. start=0 -> stay.
- SETTLE: cnt increments each cycle; when cnt==SETTLE-1, go SAMPLE (exactly SETTLE cycles in SETTLE per vector). vec_out stable.
- SAMPLE (one cycle): mismatch = dut_y != EXP_TABLE[vec_out].
  - On mismatch: err_count+1. If fail_valid==0, fail_vec<=vec_out and fail_valid<=1. Later mismatches do not overwrite fail_vec.
  - If vec_out == 2**N_IN-1, go DONE and leave vec_out unchanged.
  - Else vec_out+1, cnt<=0, go SETTLE.
- DONE (one cycle): done=1, busy=0, pass<=(err_count==0), go IDLE. err_count/fail_* held.
- Timing: start accepted at edge 0. Vector k is on vec_out from cycle k*(SETTLE+1)+1 and sampled at cycle k*(SETTLE+1)+SETTLE+1. done is high in cycle 2**N_IN*(SETTLE+1)+1 (N_IN=2, SETTLE=1: cycle 9).
- start while busy or in DONE: ignored, no effect.
- start held high continuously: a new sweep begins on the first IDLE cycle after DONE.
- err_count max 2**N_IN fits N_IN+1 bits; no saturation, no wrap.
- dut_y is combinational from vec_out; the block adds no registering on dut_y; sampling occurs only in SAMPLE.

Test Plan:
- Defaults, ideal AND model on dut_y, pulse start: vec_out 0,1,2,3 each held 2 cycles. done at cycle 9, pass=1, err_count=0, fail_valid=0.
- dut_y tied to OR of inputs: mismatches at vectors 1 and 2. err_count=2, fail_vec=2'b01, fail_valid=1, pass=0.
- dut_y stuck at 1: err_count=3, fail_vec=0, pass=0. Next sweep with a correct AND: counters clear on start, pass=1.
- SETTLE=3, N_IN=3, EXP_TABLE=8'b1001_0110 (XOR3), ideal model: each vector held 4 cycles. done at cycle 33, pass=1.
- rst asserted at cycle 5 of a default sweep: next cycle all outputs 0, state IDLE, no done pulse. Re-start completes normally.
- start pulsed at cycles 3 and 9 of a running default sweep: ignored. Exactly one done at cycle 9; vector order unchanged.
